hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
Pipeline interlock and forwarding controller for the 16-bit, 4-bit-opcode core. Sits beside the decode stage and watches the instruction in decode plus the destination/write-enable of the instructions in execute and memory. Generates fetch/decode enables, flush and bubble controls, and operand forwarding selects. Sequences load-use stalls, taken-branch flushes and halt/resume through a small FSM.

Parameters:
LOAD_LAT, 1, stall cycles inserted on a load-use hazard (1..7)
FLUSH_CYC, 1, bubble cycles inserted after a taken branch/jump (1..3)
CNT_W, 16, width of the optional performance counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
id_rs1  in  4  decode source 1, instruction bits [11:8]
id_rs2  in  4  decode source 2, instruction bits [7:4]
id_use1  in  1  decode instruction reads rs1
id_use2  in  1  decode instruction reads rs2
id_halt  in  1  decode instruction is HALT
ex_dest  in  4  execute-stage destination
ex_we  in  1  execute-stage register write
ex_load  in  1  execute-stage instruction is a load
mem_dest  in  4  memory-stage destination
mem_we  in  1  memory-stage register write
br_taken  in  1  execute stage resolves a taken branch/jump (1-cycle pulse)
resume  in  1  leave HALT (1-cycle pulse)
pc_en  out  1  fetch PC update enable
ifid_en  out  1  fetch/decode register enable
ifid_flush  out  1  clear fetch/decode register to NOP
idex_bubble  out  1  force we=0, branch=00 into execute (same effect as bj path)
fwd_a  out  2  operand-1 source: 00 regfile, 01 EX result, 10 MEM result
fwd_b  out  2  operand-2 source, same encoding
halted  out  1  FSM is in HALT
stall_cnt  out  CNT_W  optional, see below
flush_cnt  out  CNT_W  optional, see below

Behaviour:
- Reset: asynchronous, active-low (rst=0). FSM -> RUN, counters -> 0. While rst=0: pc_en=0, ifid_en=0, ifid_flush=1, idex_bubble=1, fwd_a=fwd_b=00, halted=0.
- States: RUN, STALL, FLUSH, HALT. 3-bit down-counter cnt. State and cnt are registered; outputs are combinational from state and inputs, so a hazard is acted on in the cycle it is detected.
- Hazard term: luh = ex_load & ex_we & ((id_use1 & ex_dest==id_rs1) | (id_use2 & ex_dest==id_rs2)).
- Forwarding, combinational, every state: fwd_a=01 if id_use1 & ex_we & ~ex_load & ex_dest==id_rs1; else 10 if id_use1 & mem_we & mem_dest==id_rs1; else 00. fwd_b is the same using rs2/use2. EX has priority over MEM. All 16 registers are forwardable; there is no hard-wired zero register.
- Priority within a cycle: br_taken > luh > id_halt.
- RUN:
  - br_taken: ifid_flush=1, idex_bubble=1, pc_en=1. If FLUSH_CYC>1, go to FLUSH with cnt=FLUSH_CYC-1.
  - else luh: pc_en=0, ifid_en=0, idex_bubble=1. Go to STALL with cnt=LOAD_LAT-1 if LOAD_LAT>1; otherwise stay in RUN, since the load has then advanced and the hazard clears.
  - else id_halt: pc_en=0, ifid_en=0, idex_bubble=0 (HALT enters execute). Go to HALT.
  - else pc_en=1, ifid_en=1, ifid_flush=0, idex_bubble=0.
- STALL: pc_en=0, ifid_en=0, idex_bubble=1, cnt decrements; at cnt=0 go to RUN. br_taken in STALL aborts it: flush outputs as in RUN, go to RUN/FLUSH.
- FLUSH: ifid_flush=1, idex_bubble=1, pc_en=1, cnt decrements; at cnt=0 go to RUN. A further br_taken reloads cnt=FLUSH_CYC-1.
- HALT: halted=1, pc_en=0, ifid_en=0, idex_bubble=1. resume=1 -> RUN, with ifid_flush=1 that cycle to discard the HALT in decode. br_taken in HALT is ignored.
- Reset mid-operation: immediate return to the reset values above; any stall or flush in progress is discarded.

Optional Feature:
HAZARD_CTRL_PERF_EN. When defined, stall_cnt increments on every cycle with pc_en=0 & ~halted & rst=1, and flush_cnt increments on every cycle with ifid_flush=1 & rst=1. Both saturate at all-ones and are cleared only by reset. When undefined, both ports are tied to 0 and no counter flops are built.

Test Plan:
- Reset: rst=0 with clk running -> pc_en=0, idex_bubble=1, ifid_flush=1. Release rst -> pc_en=1, ifid_en=1 on the next edge.
- Forwarding: id_rs1=3, id_use1=1, ex_we=1, ex_dest=3, mem_we=1, mem_dest=3 -> fwd_a=01. Then ex_we=0 -> fwd_a=10. Then id_use1=0 -> fwd_a=00.
- Load-use: ex_load=1, ex_we=1, ex_dest=5, id_rs2=5, id_use2=1 -> exactly 1 cycle of pc_en=0/idex_bubble=1. Repeat with LOAD_LAT=3 -> 3 cycles.
- Branch vs load-use in the same cycle: br_taken=1 and luh=1 -> ifid_flush=1, pc_en=1, no stall cycle. With FLUSH_CYC=2 -> 2 flush cycles.
- Halt: id_halt=1 -> halted=1 the next cycle; pc_en remains 0 for 10 cycles. resume pulse -> ifid_flush=1 for 1 cycle, then RUN.
- Perf (HAZARD_CTRL_PERF_EN defined): 3 load-use stalls + 2 branches with defaults -> stall_cnt=3, flush_cnt=2. Forcing a count of 0xFFFF, one more stall -> count stays 0xFFFF.

Source files
------------

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl -- pipeline interlock and forwarding controller
//
// Watches the instruction in decode together with the destination/write
// enables of the execute and memory stages. Produces fetch/decode enables,
// flush/bubble controls and operand forwarding selects. Load-use stalls,
// taken-branch flushes and HALT/resume are sequenced by a four-state FSM
// with a 3-bit down-counter. Outputs are combinational from the registered
// state and the current inputs, so a hazard is acted on in the cycle it is
// detected.
//
// Parameters:
//   LOAD_LAT  stall cycles inserted on a load-use hazard (1..7)
//   FLUSH_CYC bubble cycles inserted after a taken branch/jump (1..3)
//   CNT_W     width of the optional performance counters
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-low reset
//   id_rs1/id_rs2, id_use*   decode source registers and their read flags
//   id_halt                  decode instruction is HALT
//   ex_dest/ex_we/ex_load    execute-stage destination, write, load flag
//   mem_dest/mem_we          memory-stage destination and write
//   br_taken                 taken branch/jump resolved in execute (pulse)
//   resume                   leave HALT (pulse)
//   pc_en, ifid_en           fetch PC / fetch-decode register enables
//   ifid_flush, idex_bubble  clear fetch-decode / inject bubble into execute
//   fwd_a, fwd_b             operand sources: 00 regfile, 01 EX, 10 MEM
//   halted                   FSM is in HALT
//   stall_cnt, flush_cnt     performance counters (zero unless enabled)
//
// Optional feature: define HAZARD_CTRL_PERF_EN to build the saturating
// stall/flush performance counters.
// ---------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int LOAD_LAT  = 1,
    parameter int FLUSH_CYC = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       id_rs1,
    input  logic [3:0]       id_rs2,
    input  logic             id_use1,
    input  logic             id_use2,
    input  logic             id_halt,
    input  logic [3:0]       ex_dest,
    input  logic             ex_we,
    input  logic             ex_load,
    input  logic [3:0]       mem_dest,
    input  logic             mem_we,
    input  logic             br_taken,
    input  logic             resume,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        S_RUN,
        S_STALL,
        S_FLUSH,
        S_HALT
    } state_t;

    localparam logic [2:0] LOAD_RELOAD  = 3'(LOAD_LAT - 1);
    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYC - 1);

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       luh;
    logic [2:0] cnt_dec;

    assign luh = ex_load & ex_we &
                 ((id_use1 & (ex_dest == id_rs1)) | (id_use2 & (ex_dest == id_rs2)));
    assign cnt_dec = cnt_q - 3'd1;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values; combinational blocks use blocking (=).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_RUN;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // left one unassigned would infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        halted      = 1'b0;

        if (br_taken && (state_q != S_HALT)) begin
            // A taken branch wins over everything outside HALT, including an
            // in-progress stall or flush (which it restarts).
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            if (FLUSH_CYC > 1) begin
                state_d = S_FLUSH;
                cnt_d   = FLUSH_RELOAD;
            end else begin
                state_d = S_RUN;
                cnt_d   = 3'd0;
            end
        end else begin
            unique case (state_q)
                S_RUN: begin
                    if (luh) begin
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_bubble = 1'b1;
                        // With a single cycle the load has moved on by the next
                        // edge, so there is nothing left to count down.
                        if (LOAD_LAT > 1) begin
                            state_d = S_STALL;
                            cnt_d   = LOAD_RELOAD;
                        end
                    end else if (id_halt) begin
                        // HALT itself proceeds into execute; fetch freezes.
                        pc_en   = 1'b0;
                        ifid_en = 1'b0;
                        state_d = S_HALT;
                    end
                end
                S_STALL: begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_bubble = 1'b1;
                    cnt_d       = cnt_dec;
                    if (cnt_dec == 3'd0) state_d = S_RUN;
                end
                S_FLUSH: begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    cnt_d       = cnt_dec;
                    if (cnt_dec == 3'd0) state_d = S_RUN;
                end
                S_HALT: begin
                    halted      = 1'b1;
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_bubble = 1'b1;
                    if (resume) begin
                        // Discard the HALT still sitting in decode; the PC is
                        // held so the following instruction is fetched next.
                        ifid_flush = 1'b1;
                        state_d    = S_RUN;
                    end
                end
                default: state_d = S_RUN;
            endcase
        end

        // Reset overrides the combinational outputs while rst is low.
        if (!rst) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            halted      = 1'b0;
        end
    end

    // Forwarding: EX beats MEM; a load in EX has no result yet (that case is
    // the load-use stall instead).
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (id_use1 && ex_we && !ex_load && (ex_dest == id_rs1)) fwd_a = 2'b01;
        else if (id_use1 && mem_we && (mem_dest == id_rs1))     fwd_a = 2'b10;
        if (id_use2 && ex_we && !ex_load && (ex_dest == id_rs2)) fwd_b = 2'b01;
        else if (id_use2 && mem_we && (mem_dest == id_rs2))     fwd_b = 2'b10;
        if (!rst) begin
            fwd_a = 2'b00;
            fwd_b = 2'b00;
        end
    end

`ifdef HAZARD_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_en && !halted && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
        if (ifid_flush && (flush_cnt_q != '1))       flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
